// File: rtl/arb_pkg.sv
// Shared types and defaults for the unified-memory arbiter (mem_arbiter).
// Holds the FSM state enum, the grant-source enum and the fixed-priority winner function.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } arbState_e;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_I    = 2'd1,
        SRC_D    = 2'd2
    } grantSrc_e;

    localparam int unsigned STARVE_MAX_DEF = 4;
    localparam int unsigned TIMEOUT_DEF    = 64;
    localparam int unsigned PERF_W         = 16;

    // D wins a tie unless the I side has been starved for STARVE_MAX grants.
    function automatic grantSrc_e pickWinner(input logic iReq, input logic dReq, input logic starved);
        grantSrc_e src;
        if (dReq && !(iReq && starved)) begin
            src = SRC_D;
        end else if (iReq) begin
            src = SRC_I;
        end else begin
            src = SRC_NONE;
        end
        return src;
    endfunction

endpackage

// File: rtl/arb_sat_counter.sv
// Saturating up-counter with synchronous clear; used for the starvation count
// and for the optional performance counters of mem_arbiter.
module arb_sat_counter #(
    parameter int unsigned W   = 16,
    parameter logic [W-1:0] MAX = '1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt
);

    // Clear has priority over increment; the count sticks at MAX.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != MAX)) begin
            cnt <= cnt + {{(W-1){1'b0}}, 1'b1};
        end else begin
            cnt <= cnt;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares main memory between I-cache and D-cache: D-over-I priority, I anti-starvation,
// memory timeout, one transaction at a time. ARB_PERF_CNT_EN enables the grant/conflict counters.
module mem_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned AW         = 16,
    parameter int unsigned DW         = 16,
    parameter int unsigned STARVE_MAX = STARVE_MAX_DEF,
    parameter int unsigned TIMEOUT    = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [AW-1:0]     i_addr,
    output logic              i_done,
    output logic [DW-1:0]     i_rdata,
    input  logic              d_req,
    input  logic              d_wr,
    input  logic [AW-1:0]     d_addr,
    input  logic [DW-1:0]     d_wdata,
    output logic              d_done,
    output logic [DW-1:0]     d_rdata,
    output logic              mem_req,
    output logic              mem_wr,
    output logic [AW-1:0]     mem_addr,
    output logic [DW-1:0]     mem_wdata,
    input  logic              mem_done,
    input  logic [DW-1:0]     mem_rdata,
    output logic              err,
    output logic [PERF_W-1:0] i_grant_cnt,
    output logic [PERF_W-1:0] d_grant_cnt,
    output logic [PERF_W-1:0] conflict_cnt
);

    localparam int unsigned SW = $clog2(STARVE_MAX + 1);
    localparam int unsigned TW = $clog2(TIMEOUT);

    arbState_e   state_r;
    logic [TW-1:0] tmoCnt_r;
    logic [SW-1:0] starveCnt_s;

    logic      iReqM_s;
    logic      dReqM_s;
    logic      isIdle_s;
    logic      starved_s;
    grantSrc_e winner_s;
    logic      iGrant_s;
    logic      dGrant_s;
    logic      starveInc_s;
    logic      starveClr_s;
    logic      tmoHit_s;

    // Mask the requester that just completed, then pick this cycle's winner.
    always_comb begin
        iReqM_s   = i_req & ~i_done;
        dReqM_s   = d_req & ~d_done;
        isIdle_s  = (state_r == IDLE);
        starved_s = (starveCnt_s == SW'(STARVE_MAX));
        if (isIdle_s) begin
            winner_s = pickWinner(iReqM_s, dReqM_s, starved_s);
        end else begin
            winner_s = SRC_NONE;
        end
        iGrant_s    = (winner_s == SRC_I);
        dGrant_s    = (winner_s == SRC_D);
        starveInc_s = dGrant_s & iReqM_s;
        starveClr_s = iGrant_s | (isIdle_s & ~iReqM_s);
        tmoHit_s    = (tmoCnt_r == TW'(TIMEOUT - 1));
    end

    arb_sat_counter #(
        .W   (SW),
        .MAX (SW'(STARVE_MAX))
    ) u_starve (
        .clk (clk),
        .rst (rst),
        .clr (starveClr_s),
        .en  (starveInc_s),
        .cnt (starveCnt_s)
    );

    // Arbitration FSM: latch the winner, wait for mem_done or timeout, pulse the result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            tmoCnt_r  <= '0;
            mem_req   <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            i_done    <= 1'b0;
            d_done    <= 1'b0;
            i_rdata   <= '0;
            d_rdata   <= '0;
            err       <= 1'b0;
        end else begin
            i_done <= 1'b0;
            d_done <= 1'b0;
            err    <= 1'b0;
            case (state_r)
                IDLE: begin
                    tmoCnt_r <= '0;
                    if (dGrant_s) begin
                        state_r   <= GNT_D;
                        mem_req   <= 1'b1;
                        mem_wr    <= d_wr;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                    end else if (iGrant_s) begin
                        state_r   <= GNT_I;
                        mem_req   <= 1'b1;
                        mem_wr    <= 1'b0;
                        mem_addr  <= i_addr;
                        mem_wdata <= '0;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                GNT_I, GNT_D: begin
                    // Completion beats a timeout expiring in the same cycle.
                    if (mem_done) begin
                        state_r  <= IDLE;
                        tmoCnt_r <= '0;
                        mem_req  <= 1'b0;
                        mem_wr   <= 1'b0;
                        if (state_r == GNT_I) begin
                            i_done  <= 1'b1;
                            i_rdata <= mem_rdata;
                        end else begin
                            d_done  <= 1'b1;
                            d_rdata <= mem_wr ? '0 : mem_rdata;
                        end
                    end else if (tmoHit_s) begin
                        state_r  <= IDLE;
                        tmoCnt_r <= '0;
                        mem_req  <= 1'b0;
                        mem_wr   <= 1'b0;
                        err      <= 1'b1;
                    end else begin
                        tmoCnt_r <= tmoCnt_r + TW'(1);
                    end
                end
                default: begin
                    state_r  <= IDLE;
                    tmoCnt_r <= '0;
                    mem_req  <= 1'b0;
                    mem_wr   <= 1'b0;
                end
            endcase
        end
    end

`ifdef ARB_PERF_CNT_EN
    logic conflict_s;

    // A conflict is an arbitration cycle in which both masked requests are pending.
    always_comb begin
        conflict_s = isIdle_s & iReqM_s & dReqM_s;
    end

    arb_sat_counter #(.W(PERF_W)) u_iGrantCnt (
        .clk (clk),
        .rst (rst),
        .clr (1'b0),
        .en  (iGrant_s),
        .cnt (i_grant_cnt)
    );

    arb_sat_counter #(.W(PERF_W)) u_dGrantCnt (
        .clk (clk),
        .rst (rst),
        .clr (1'b0),
        .en  (dGrant_s),
        .cnt (d_grant_cnt)
    );

    arb_sat_counter #(.W(PERF_W)) u_conflictCnt (
        .clk (clk),
        .rst (rst),
        .clr (1'b0),
        .en  (conflict_s),
        .cnt (conflict_cnt)
    );
`else
    assign i_grant_cnt  = '0;
    assign d_grant_cnt  = '0;
    assign conflict_cnt = '0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a transaction-level model plans every grant of a round,
// a memory responder follows the plan and a monitor checks what the DUT presents.
module tb_mem_arbiter;

    localparam int STARVE_MAX = 4;
    localparam int TIMEOUT    = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_req = 1'b0, d_req = 1'b0, d_wr = 1'b0;
    logic [15:0] i_addr = 16'h0, d_addr = 16'h0, d_wdata = 16'h0;
    logic        i_done, d_done, mem_req, mem_wr, err;
    logic [15:0] i_rdata, d_rdata, mem_addr, mem_wdata;
    logic        mem_done;
    logic [15:0] mem_rdata;
    logic [15:0] i_grant_cnt, d_grant_cnt, conflict_cnt;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_done(mem_done), .mem_rdata(mem_rdata), .err(err),
        .i_grant_cnt(i_grant_cnt), .d_grant_cnt(d_grant_cnt), .conflict_cnt(conflict_cnt)
    );

    // kind: 0 = completes after lat cycles, 1 = memory never answers, 2 = aborted by reset
    typedef struct {
        bit          isD;
        bit          wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        int          kind;
        int          lat;
        logic [15:0] rdata;
    } txn_t;

    txn_t grantQ[$];
    txn_t planQ[$];
    int   total = 0;
    int   bad = 0;
    int   expIGr = 0, expDGr = 0, expConf = 0;

    function automatic void chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: walk the arbitration of one round and queue every grant it implies.
    function automatic void planRound(input bit ri, input bit rd, input logic [15:0] ia,
                                      input logic [15:0] da, input bit dw, input logic [15:0] dwd,
                                      input int forceTmo, input int fixLat, input logic [15:0] fixRd);
        bit pi = ri;
        bit pd = rd;
        int starve = 0;
        int tmoLeft = 2;
        int forced = forceTmo;
        txn_t t;
        while (pi || pd) begin
            if (pi && pd) expConf++;
            if (pd && !(pi && starve == STARVE_MAX)) begin
                if (pi) starve = (starve < STARVE_MAX) ? starve + 1 : starve;
                else starve = 0;
                expDGr++;
                t.isD = 1'b1; t.wr = dw; t.addr = da; t.wdata = dwd;
            end else begin
                starve = 0;
                expIGr++;
                t.isD = 1'b0; t.wr = 1'b0; t.addr = ia; t.wdata = 16'h0;
            end
            t.lat = 0;
            if (forced > 0 && t.isD) begin
                t.kind = 1; forced--;
            end else if (fixLat > 0) begin
                t.kind = 0; t.lat = fixLat;
            end else if (tmoLeft > 0 && $urandom_range(0, 11) == 0) begin
                t.kind = 1; tmoLeft--;
            end else begin
                t.kind = 0;
                t.lat = ($urandom_range(0, 15) == 0) ? TIMEOUT : int'($urandom_range(1, 6));
            end
            t.rdata = (fixLat > 0) ? fixRd : 16'($urandom);
            if (t.kind == 0) begin
                if (t.isD) pd = 1'b0;
                else pi = 1'b0;
            end
            grantQ.push_back(t);
            planQ.push_back(t);
        end
    endfunction

    // Requesters hold req until they see their done pulse at an edge, then drop it.
    task automatic serve(input int budget);
        bit iDrop = 1'b0;
        bit dDrop = 1'b0;
        int n = 0;
        while ((i_req || d_req) && n < budget) begin
            @(negedge clk);
            n++;
            if (iDrop) i_req = 1'b0;
            if (dDrop) d_req = 1'b0;
            iDrop = i_done;
            dDrop = d_done;
        end
        if (i_req || d_req) begin
            chk("round_budget", n, 0);
            i_req = 1'b0;
            d_req = 1'b0;
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic runRound(input bit ri, input bit rd, input logic [15:0] ia, input logic [15:0] da,
                            input bit dw, input logic [15:0] dwd, input int forceTmo,
                            input int fixLat, input logic [15:0] fixRd);
        planRound(ri, rd, ia, da, dw, dwd, forceTmo, fixLat, fixRd);
        @(negedge clk);
        i_addr = ia; d_addr = da; d_wr = dw; d_wdata = dwd;
        i_req = ri; d_req = rd;
        serve(3000);
    endtask

    // Memory responder: answers each grant as planned, plus stray mem_done pulses while idle.
    initial begin
        txn_t rp;
        bit   ractive;
        int   rcnt;
        mem_done = 1'b0; mem_rdata = 16'h0; ractive = 1'b0; rcnt = 0;
        forever begin
            @(negedge clk);
            mem_done = 1'b0;
            if (rst) begin
                ractive = 1'b0;
            end else begin
                if (ractive && !mem_req) ractive = 1'b0;
                if (!ractive && mem_req && planQ.size() > 0) begin
                    rp = planQ.pop_front();
                    ractive = 1'b1;
                    rcnt = 0;
                end
                if (ractive) begin
                    rcnt++;
                    if (rp.kind == 0 && rcnt == rp.lat) begin
                        mem_done = 1'b1;
                        mem_rdata = rp.rdata;
                    end
                end else if (!mem_req && $urandom_range(0, 7) == 0) begin
                    mem_done = 1'b1;
                    mem_rdata = 16'($urandom);
                end
            end
        end
    end

    // Monitor: pop the expected grant on each mem_req rise and check the bus and the response.
    initial begin
        txn_t cur;
        bit   active, prevReq;
        int   cyc, start, expLat;
        logic [15:0] sAddr, sWdata;
        logic sWr;
        active = 1'b0; prevReq = 1'b0; cyc = 0; start = 0; expLat = 0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (rst) begin
                if (active) chk("rst_abort_kind", cur.kind, 2);
                active = 1'b0;
                prevReq = 1'b0;
            end else begin
                if (mem_req && !prevReq) begin
                    if (active || grantQ.size() == 0) begin
                        chk("unexpected_grant", int'(mem_addr), -1);
                    end else begin
                        cur = grantQ.pop_front();
                        active = 1'b1;
                        start = cyc;
                        expLat = (cur.kind == 1) ? TIMEOUT : cur.lat;
                        chk("mem_addr", int'(mem_addr), int'(cur.addr));
                        chk("mem_wr", int'(mem_wr), int'(cur.wr));
                        if (cur.isD && cur.wr) chk("mem_wdata", int'(mem_wdata), int'(cur.wdata));
                        sAddr = mem_addr; sWdata = mem_wdata; sWr = mem_wr;
                    end
                end else if (mem_req && active) begin
                    chk("mem_stable", int'({sWr, sAddr, sWdata} != {mem_wr, mem_addr, mem_wdata}), 0);
                end
                if (i_done || d_done || err) begin
                    if (!active) begin
                        chk("stray_response", int'({i_done, d_done, err}), 0);
                    end else begin
                        chk("i_done", int'(i_done), int'(cur.kind == 0 && !cur.isD));
                        chk("d_done", int'(d_done), int'(cur.kind == 0 && cur.isD));
                        chk("err", int'(err), int'(cur.kind == 1));
                        chk("latency", cyc - start, expLat);
                        chk("mem_req_drop", int'(mem_req), 0);
                        if (i_done) chk("i_rdata", int'(i_rdata), int'(cur.rdata));
                        if (d_done) chk("d_rdata", int'(d_rdata), cur.wr ? 0 : int'(cur.rdata));
                        active = 1'b0;
                    end
                end else if (active && (cyc - start) > expLat) begin
                    chk("response_missing", cyc - start, expLat);
                    active = 1'b0;
                end
                prevReq = mem_req;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: run exceeded its time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        txn_t t;
        bit   ri, rd;
        int   sel, n;
        repeat (3) @(negedge clk);
        chk("rst_mem_req", int'(mem_req), 0);
        chk("rst_mem_wr", int'(mem_wr), 0);
        chk("rst_mem_addr", int'(mem_addr), 0);
        chk("rst_dones", int'({i_done, d_done, err}), 0);
        chk("rst_rdata", int'({i_rdata, d_rdata}), 0);
        chk("rst_perf", int'(i_grant_cnt | d_grant_cnt | conflict_cnt), 0);
        rst = 1'b0;
        @(negedge clk);

        runRound(1'b1, 1'b0, 16'h0040, 16'h0, 1'b0, 16'h0, 0, 3, 16'hBEEF);
        runRound(1'b1, 1'b1, 16'h0080, 16'h1000, 1'b1, 16'h1234, 0, 2, 16'h5A5A);
        runRound(1'b1, 1'b1, 16'h00C0, 16'h2000, 1'b0, 16'h0, 4, 0, 16'h0);
        runRound(1'b0, 1'b1, 16'h0, 16'h3000, 1'b0, 16'h0, 1, 0, 16'h0);
        runRound(1'b1, 1'b0, 16'h0100, 16'h0, 1'b0, 16'h0, 0, TIMEOUT, 16'hC0DE);

        // Asynchronous reset two cycles into a D read, then a clean regrant.
        t.isD = 1'b1; t.wr = 1'b0; t.addr = 16'h2222; t.wdata = 16'h0;
        t.kind = 2; t.lat = 1000; t.rdata = 16'h0;
        grantQ.push_back(t); planQ.push_back(t);
        @(negedge clk);
        d_addr = 16'h2222; d_wr = 1'b0; d_req = 1'b1;
        n = 0;
        while (!mem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("rst_test_grant", int'(mem_req), 1);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        expIGr = 0; expDGr = 0; expConf = 0;
        #1;
        chk("async_rst_mem_req", int'(mem_req), 0);
        chk("async_rst_mem_addr", int'(mem_addr), 0);
        chk("async_rst_outs", int'({mem_wr, i_done, d_done, err}), 0);
        t.kind = 0; t.lat = 3; t.rdata = 16'h7E57;
        grantQ.push_back(t); planQ.push_back(t);
        expDGr = 1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        serve(200);

        for (int r = 0; r < 60; r++) begin
            sel = int'($urandom_range(0, 2));
            ri = (sel != 1);
            rd = (sel != 0);
            runRound(ri, rd, 16'($urandom), 16'($urandom), 1'($urandom), 16'($urandom), 0, 0, 16'h0);
        end

        repeat (5) @(negedge clk);
        chk("grant_queue_drained", grantQ.size(), 0);
        chk("plan_queue_drained", planQ.size(), 0);
`ifdef ARB_PERF_CNT_EN
        chk("i_grant_cnt", int'(i_grant_cnt), expIGr);
        chk("d_grant_cnt", int'(d_grant_cnt), expDGr);
        chk("conflict_cnt", int'(conflict_cnt), expConf);
`else
        chk("i_grant_cnt", int'(i_grant_cnt), 0);
        chk("d_grant_cnt", int'(d_grant_cnt), 0);
        chk("conflict_cnt", int'(conflict_cnt), 0);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
